reg_scoreboard: RTL and testbench

//  Producer-side hazard tracker for the 5-stage pipeline; pairs with the forwarding path.
//  - Marks each register destination when its instruction issues from ID to EXE.
//  - Clears the mark when that register is written back.
//  - Raises stall when an ID-stage source reads a register whose value is still in flight.
//  - Sits between ID and EXE; its stall freezes IF/ID and inserts a bubble into EXE.

---
 rtl/reg_scoreboard.sv | 130 +++++++++++++
 tb/tb_reg_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Producer-side hazard tracker for the 5-stage pipeline, sitting between ID
//   and EXE. Each architectural register (except r0) carries a small counter
//   of in-flight writes plus a flag saying whether the youngest of those writes
//   is a load. Sources read in ID are checked against this state and stall is
//   raised while a needed value is still in flight.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous reset, active-high (priority over flush)
//   flush_i          pipeline flush: drop all pending state
//   issue_valid_i    instruction in ID presented for issue
//   issue_wb_en_i    issuing instruction writes a register
//   issue_is_load_i  issuing instruction is a load
//   issue_dest_i     destination of the issuing instruction
//   src1_i, src2_i   ID-stage source indices
//   src2_used_i      src2 is a register operand
//   wb_valid_i       WB stage writes a register this cycle
//   wb_dest_i        register being written back
//   stall_o          ID must hold (combinational)
//   issue_fire_o     issue accepted this cycle
//   err_underflow_o  registered pulse: writeback to a non-pending register
//
// Configuration
//   REG_SCOREBOARD_FWD_AWARE_EN  defined: only load-use dependencies stall,
//                                ALU results are assumed forwarded.
//                                undefined: any pending write stalls.

module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  input  logic              issue_wb_en_i,
  input  logic              issue_is_load_i,
  input  logic [ADDR_W-1:0] issue_dest_i,
  input  logic [ADDR_W-1:0] src1_i,
  input  logic [ADDR_W-1:0] src2_i,
  input  logic              src2_used_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_dest_i,
  output logic              stall_o,
  output logic              issue_fire_o,
  output logic              err_underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             ld_q  [NUM_REGS];
  logic             ld_d  [NUM_REGS];
  logic             err_underflow_q;
  logic             err_underflow_d;

  logic busy1, busy2;
  logic dep1, dep2;
  logic wb_hit, wb_ok, wb_under;
  logic dec_same, sat;
  logic do_issue;

  // r0 is never tracked, so a zero index can never be busy.
  assign busy1 = (src1_i != '0) && (cnt_q[src1_i] != '0);
  assign busy2 = (src2_i != '0) && (cnt_q[src2_i] != '0);

`ifdef REG_SCOREBOARD_FWD_AWARE_EN
  // ALU results reach the consumer through forwarding; only a load still in
  // flight cannot be forwarded in time.
  assign dep1 = busy1 & ld_q[src1_i];
  assign dep2 = busy2 & ld_q[src2_i] & src2_used_i;
`else
  assign dep1 = busy1;
  assign dep2 = busy2 & src2_used_i;
`endif

  assign wb_hit   = wb_valid_i && (wb_dest_i != '0);
  assign wb_ok    = wb_hit && (cnt_q[wb_dest_i] != '0);
  assign wb_under = wb_hit && (cnt_q[wb_dest_i] == '0);

  // A full counter may still accept an issue if the same register retires one
  // write in this cycle, since the net count stays the same.
  assign dec_same = wb_ok && (wb_dest_i == issue_dest_i);
  assign sat      = issue_wb_en_i && (cnt_q[issue_dest_i] == CNT_MAX) && !dec_same;

  assign stall_o      = issue_valid_i & (dep1 | dep2 | sat);
  assign issue_fire_o = issue_valid_i & ~stall_o;
  assign do_issue     = issue_fire_o && issue_wb_en_i && (issue_dest_i != '0);

  // Writeback is applied before issue so a same-register pair nets to an
  // unchanged count and the load flag ends up with the issuing instruction's value.
  always_comb begin
    cnt_d           = cnt_q;
    ld_d            = ld_q;
    err_underflow_d = wb_under;
    if (wb_ok) begin
      cnt_d[wb_dest_i] = cnt_q[wb_dest_i] - CNT_ONE;
      if (cnt_q[wb_dest_i] == CNT_ONE) begin
        ld_d[wb_dest_i] = 1'b0;
      end
    end
    if (do_issue) begin
      cnt_d[issue_dest_i] = cnt_d[issue_dest_i] + CNT_ONE;
      ld_d[issue_dest_i]  = issue_is_load_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
        ld_q[r]  <= 1'b0;
      end
      err_underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
        ld_q[r]  <= ld_d[r];
      end
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_underflow_o = err_underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
//   Directed bench for reg_scoreboard. Inputs change shortly after a rising
//   edge, combinational outputs are sampled 1 time unit later, and the registered
//   underflow flag is sampled 1 time unit after the committing edge.

module tb_reg_scoreboard;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic       issue_valid_i;
  logic       issue_wb_en_i;
  logic       issue_is_load_i;
  logic [4:0] issue_dest_i;
  logic [4:0] src1_i;
  logic [4:0] src2_i;
  logic       src2_used_i;
  logic       wb_valid_i;
  logic [4:0] wb_dest_i;
  logic       stall_o;
  logic       issue_fire_o;
  logic       err_underflow_o;

  int totalChecks = 0;
  int badChecks   = 0;

`ifdef REG_SCOREBOARD_FWD_AWARE_EN
  localparam logic ALU_RAW_STALL = 1'b0;
`else
  localparam logic ALU_RAW_STALL = 1'b1;
`endif

  always #5 clk_i = ~clk_i;

  reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_wb_en_i   (issue_wb_en_i),
    .issue_is_load_i (issue_is_load_i),
    .issue_dest_i    (issue_dest_i),
    .src1_i          (src1_i),
    .src2_i          (src2_i),
    .src2_used_i     (src2_used_i),
    .wb_valid_i      (wb_valid_i),
    .wb_dest_i       (wb_dest_i),
    .stall_o         (stall_o),
    .issue_fire_o    (issue_fire_o),
    .err_underflow_o (err_underflow_o)
  );

  task automatic checkOutput(input string tag, input logic got, input logic exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0b expected=%0b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's worth of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic iv, input logic we, input logic isLd,
                               input logic [4:0] dest, input logic [4:0] s1,
                               input logic [4:0] s2, input logic s2u,
                               input logic wv, input logic [4:0] wd, input logic fl);
    issue_valid_i   = iv;
    issue_wb_en_i   = we;
    issue_is_load_i = isLd;
    issue_dest_i    = dest;
    src1_i          = s1;
    src2_i          = s2;
    src2_used_i     = s2u;
    wb_valid_i      = wv;
    wb_dest_i       = wd;
    flush_i         = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue a register-writing instruction with no source dependencies.
  task automatic issueTo(input logic [4:0] dest, input logic isLd, input string tag);
    applyStimulus(1'b1, 1'b1, isLd, dest, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput(tag, issue_fire_o, 1'b1);
    tick();
  endtask

  task automatic writeBack(input logic [4:0] dest);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, dest, 1'b0);
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    tick();
    rst_i = 1'b0;
    checkOutput("reset_err", err_underflow_o, 1'b0);

    // Reset state: nothing pending
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("reset_stall", stall_o, 1'b0);
    checkOutput("reset_fire", issue_fire_o, 1'b1);
    tick();

    // ALU RAW on r3
    issueTo(5'd3, 1'b0, "raw_issue_fire");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_stall", stall_o, ALU_RAW_STALL);
    checkOutput("raw_fire", issue_fire_o, ~ALU_RAW_STALL);
    tick();
    writeBack(5'd3);
    checkOutput("raw_wb_no_err", err_underflow_o, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_after_wb_stall", stall_o, 1'b0);
    tick();

    // Load-use on r4 through src2
    issueTo(5'd4, 1'b1, "lu_issue_fire");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("lu_stall", stall_o, 1'b1);
    checkOutput("lu_fire", issue_fire_o, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("lu_imm_stall", stall_o, 1'b0);
    tick();
    writeBack(5'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("lu_after_wb_stall", stall_o, 1'b0);
    tick();

    // Saturation on r7 (CNT_W=2 -> max 3 in flight)
    issueTo(5'd7, 1'b0, "sat_issue1");
    issueTo(5'd7, 1'b0, "sat_issue2");
    issueTo(5'd7, 1'b0, "sat_issue3");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("sat_stall", stall_o, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("sat_hold_stall", stall_o, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    checkOutput("sat_dec_same_fire", issue_fire_o, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("sat_still_full", stall_o, 1'b1);
    tick();
    // Exactly three writebacks drain r7; a fourth underflows
    writeBack(5'd7);
    writeBack(5'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("drain_one_left", stall_o, ALU_RAW_STALL);
    tick();
    writeBack(5'd7);
    checkOutput("drain_no_err", err_underflow_o, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("drain_empty_stall", stall_o, 1'b0);
    tick();

    // Underflow pulse and r0 writeback
    writeBack(5'd9);
    checkOutput("uf_pulse", err_underflow_o, 1'b1);
    idle();
    tick();
    checkOutput("uf_pulse_gone", err_underflow_o, 1'b0);
    writeBack(5'd0);
    checkOutput("uf_r0_none", err_underflow_o, 1'b0);

    // Issue to r0 is never tracked
    issueTo(5'd0, 1'b1, "r0_issue_fire");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("r0_stall", stall_o, 1'b0);
    tick();

    // Flush with pending loads on r2,r3 and a simultaneous issue to r5
    issueTo(5'd2, 1'b1, "fl_issue_r2");
    issueTo(5'd3, 1'b1, "fl_issue_r3");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("fl_pre_stall", stall_o, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("fl_r2_r3_clear", stall_o, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("fl_r5_unmarked", stall_o, 1'b0);
    tick();
    writeBack(5'd5);
    checkOutput("fl_r5_wb_underflow", err_underflow_o, 1'b1);

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
